// File: rtl/bicubic_window_sched.sv
// Frame scheduler for bicubic_upsample: walks the source in clamped 4x4
// windows, one per cycle, gated on line-buffer row residency.
module bicubic_window_sched #(
    parameter int BLOCK_SIZE = 960,
    parameter int SRC_HEIGHT = 540,
    parameter int CW         = $clog2(BLOCK_SIZE),
    parameter int RW         = $clog2(SRC_HEIGHT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] rows_avail,
    output logic          bf_req_valid,
    input  logic          bcci_req_ready,
    output logic [RW-1:0] win_row0,
    output logic [RW-1:0] win_row1,
    output logic [RW-1:0] win_row2,
    output logic [RW-1:0] win_row3,
    output logic [CW-1:0] win_col0,
    output logic [CW-1:0] win_col1,
    output logic [CW-1:0] win_col2,
    output logic [CW-1:0] win_col3,
    output logic [1:0]    phase,
    output logic [RW-1:0] min_row_needed,
    output logic          busy,
    output logic          frame_done
);

    localparam int NPASS = 4 * SRC_HEIGHT;
    localparam int PW    = $clog2(NPASS);
    // column counter must reach BLOCK_SIZE itself
    localparam int XW    = CW + 1;

    localparam logic [PW-1:0] LAST_P = PW'(NPASS - 1);
    localparam logic [XW-1:0] LAST_C = XW'(BLOCK_SIZE);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [XW-1:0] C_ONE  = XW'(1);

    localparam logic signed [RW+1:0] ROW_MAX   = (RW+2)'(SRC_HEIGHT - 1);
    localparam logic signed [RW+1:0] ROW_ONE   = (RW+2)'(1);
    localparam logic signed [RW+1:0] ROW_TWO   = (RW+2)'(2);
    localparam logic signed [RW+1:0] ROW_THREE = (RW+2)'(3);
    localparam logic signed [CW+1:0] COL_MAX   = (CW+2)'(BLOCK_SIZE - 1);
    localparam logic signed [CW+1:0] COL_ONE   = (CW+2)'(1);
    localparam logic signed [CW+1:0] COL_TWO   = (CW+2)'(2);
    localparam logic signed [CW+1:0] COL_THREE = (CW+2)'(3);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] p_q, p_n;
    logic [XW-1:0] c_q, c_n;

    function automatic logic [RW-1:0] clamp_row(input logic signed [RW+1:0] v);
        logic [RW-1:0] r;
        if (v[RW+1])
            r = '0;
        else if (v > ROW_MAX)
            r = ROW_MAX[RW-1:0];
        else
            r = v[RW-1:0];
        return r;
    endfunction

    function automatic logic [CW-1:0] clamp_col(input logic signed [CW+1:0] v);
        logic [CW-1:0] r;
        if (v[CW+1])
            r = '0;
        else if (v > COL_MAX)
            r = COL_MAX[CW-1:0];
        else
            r = v[CW-1:0];
        return r;
    endfunction

    // Top (unclamped) row: k-2 for phases 0/1, k-1 for phases 2/3.
    function automatic logic signed [RW+1:0] row_base(input logic [PW-1:0] pp);
        logic signed [RW+1:0] kk;
        kk = signed'((RW+2)'(pp[PW-1:2]));
        return pp[1] ? kk - ROW_ONE : kk - ROW_TWO;
    endfunction

    function automatic logic pass_ready(input logic [PW-1:0] pp,
                                        input logic [RW-1:0] avail);
        return avail > clamp_row(row_base(pp) + ROW_THREE);
    endfunction

    always_comb begin
        state_n = state;
        p_n     = p_q;
        c_n     = c_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT;
                    p_n     = '0;
                    c_n     = '0;
                end
            end
            WAIT: begin
                if (pass_ready(p_q, rows_avail))
                    state_n = ISSUE;
            end
            ISSUE: begin
                if (bf_req_valid && bcci_req_ready) begin
                    if (c_q == LAST_C) begin
                        c_n = '0;
                        if (p_q == LAST_P) begin
                            state_n = DONE;
                        end else begin
                            p_n     = p_q + P_ONE;
                            state_n = pass_ready(p_n, rows_avail) ? ISSUE : WAIT;
                        end
                    end else begin
                        c_n = c_q + C_ONE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic signed [RW+1:0] rb_n;
    logic signed [CW+1:0] cb_n;

    always_comb begin
        rb_n = row_base(p_n);
        cb_n = signed'((CW+2)'(c_n)) - COL_TWO;
    end

    // Indices are registered from the next counter values, so they track
    // p/c exactly and hold while a request waits for ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            p_q            <= '0;
            c_q            <= '0;
            bf_req_valid   <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            phase          <= '0;
            min_row_needed <= '0;
            win_row0       <= '0;
            win_row1       <= '0;
            win_row2       <= '0;
            win_row3       <= '0;
            win_col0       <= '0;
            win_col1       <= '0;
            win_col2       <= '0;
            win_col3       <= '0;
        end else begin
            state        <= state_n;
            p_q          <= p_n;
            c_q          <= c_n;
            bf_req_valid <= (state_n == ISSUE);
            busy         <= (state_n != IDLE);
            frame_done   <= (state_n == DONE);
            if (state_n != IDLE) begin
                phase          <= p_n[1:0];
                min_row_needed <= clamp_row(rb_n);
                win_row0       <= clamp_row(rb_n);
                win_row1       <= clamp_row(rb_n + ROW_ONE);
                win_row2       <= clamp_row(rb_n + ROW_TWO);
                win_row3       <= clamp_row(rb_n + ROW_THREE);
                win_col0       <= clamp_col(cb_n);
                win_col1       <= clamp_col(cb_n + COL_ONE);
                win_col2       <= clamp_col(cb_n + COL_TWO);
                win_col3       <= clamp_col(cb_n + COL_THREE);
            end
        end
    end

endmodule

// File: tb/tb_bicubic_window_sched.sv
// Directed bench for bicubic_window_sched on an 8x4 source.
module tb_bicubic_window_sched;

    localparam int BS       = 8;
    localparam int SH       = 4;
    localparam int CW       = 3;
    localparam int RW       = 3;
    localparam int HS_TOTAL = 4 * SH * (BS + 1);
    localparam int WB       = 2 + 5 * RW + 4 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [RW-1:0] rows_avail = '0;
    logic          bf_req_valid;
    logic [RW-1:0] win_row0, win_row1, win_row2, win_row3;
    logic [CW-1:0] win_col0, win_col1, win_col2, win_col3;
    logic [1:0]    phase;
    logic [RW-1:0] min_row_needed;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bicubic_window_sched #(
        .BLOCK_SIZE(BS),
        .SRC_HEIGHT(SH),
        .CW(CW),
        .RW(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rows_avail(rows_avail),
        .bf_req_valid(bf_req_valid),
        .bcci_req_ready(ready),
        .win_row0(win_row0),
        .win_row1(win_row1),
        .win_row2(win_row2),
        .win_row3(win_row3),
        .win_col0(win_col0),
        .win_col1(win_col1),
        .win_col2(win_col2),
        .win_col3(win_col3),
        .phase(phase),
        .min_row_needed(min_row_needed),
        .busy(busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] clr(input int x);
        if (x < 0) return '0;
        if (x > SH - 1) return RW'(SH - 1);
        return RW'(x);
    endfunction

    function automatic logic [CW-1:0] clc(input int x);
        if (x < 0) return '0;
        if (x > BS - 1) return CW'(BS - 1);
        return CW'(x);
    endfunction

    // Expected {phase, min_row, rows, cols} for the n-th handshake of a frame.
    function automatic logic [WB-1:0] model(input int n);
        int p, c, k, b;
        p = n / (BS + 1);
        c = n % (BS + 1);
        k = p / 4;
        b = ((p % 4) >= 2) ? k - 1 : k - 2;
        return {2'(p % 4), clr(b), clr(b), clr(b + 1), clr(b + 2), clr(b + 3),
                clc(c - 2), clc(c - 1), clc(c), clc(c + 1)};
    endfunction

    function automatic logic [WB-1:0] obs_win();
        return {phase, min_row_needed, win_row0, win_row1, win_row2, win_row3,
                win_col0, win_col1, win_col2, win_col3};
    endfunction

    task automatic check_accept(input int n);
        chk($sformatf("win_%0d", n), 32'(obs_win()), 32'(model(n)));
        if (n == 0) begin
            chk("p0c0_rows", 32'({win_row0, win_row1, win_row2, win_row3}),
                32'({3'd0, 3'd0, 3'd0, 3'd1}));
            chk("p0c0_cols", 32'({win_col0, win_col1, win_col2, win_col3}),
                32'({3'd0, 3'd0, 3'd0, 3'd1}));
        end
        if (n == 8)
            chk("p0c8_cols", 32'({win_col0, win_col1, win_col2, win_col3}),
                32'({3'd6, 3'd7, 3'd7, 3'd7}));
        if (n == 15 * (BS + 1))
            chk("p15_rows", 32'({win_row0, win_row1, win_row2, win_row3}),
                32'({3'd2, 3'd3, 3'd3, 3'd3}));
        if (n == 6 * (BS + 1))
            chk("p6_rows", 32'({win_row0, win_row1, win_row2, win_row3}),
                32'({3'd0, 3'd1, 3'd2, 3'd3}));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
    endtask

    task automatic accept_n(input int from, input int n);
        int hs = from;
        int cyc = 0;
        ready = 1'b1;
        while (hs < from + n && cyc < 1000) begin
            if (bf_req_valid) begin
                check_accept(hs);
                hs++;
            end
            step();
            cyc++;
        end
        chk("accept_count", 32'(hs), 32'(from + n));
    endtask

    task automatic run_frame(input int hs0, input bit rnd, input bit poke);
        int hs = hs0;
        int cyc = 0;
        bit held = 1'b0;
        bit seen = 1'b0;
        logic [WB-1:0] prev = '0;
        while (hs < HS_TOTAL && cyc < 5000) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (cyc == 40);
            if (held) chk("hold", 32'(obs_win()), 32'(prev));
            if (frame_done) chk("early_done", 32'(frame_done), 32'd0);
            if (!rnd && seen) chk("bubble", 32'(bf_req_valid), 32'd1);
            held = 1'b0;
            if (bf_req_valid) begin
                seen = 1'b1;
                if (ready) begin
                    check_accept(hs);
                    hs++;
                end else begin
                    held = 1'b1;
                    prev = obs_win();
                end
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk("hs_total", 32'(hs), 32'(HS_TOTAL));
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("valid_in_done", 32'(bf_req_valid), 32'd0);
        step();
        chk("done_clear", 32'(frame_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", 32'(bf_req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_win", 32'(obs_win()), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // full throughput
        rows_avail = 3'd4;
        pulse_start();
        chk("wait_valid", 32'(bf_req_valid), 32'd0);
        run_frame(0, 1'b0, 1'b0);

        // starvation
        rows_avail = 3'd1;
        ready = 1'b1;
        pulse_start();
        repeat (6) step();
        chk("starve_idle", 32'(bf_req_valid), 32'd0);
        rows_avail = 3'd2;
        chk("starve_pre", 32'(bf_req_valid), 32'd0);
        step();
        chk("valid_rise", 32'(bf_req_valid), 32'd1);
        accept_n(0, 2 * (BS + 1));
        chk("starve_p2", 32'(bf_req_valid), 32'd0);
        repeat (3) step();
        chk("starve_hold", 32'(bf_req_valid), 32'd0);
        chk("starve_minrow", 32'(min_row_needed), 32'd0);
        rows_avail = 3'd3;
        step();
        chk("p2_rise", 32'(bf_req_valid), 32'd1);
        rows_avail = 3'd4;
        run_frame(2 * (BS + 1), 1'b0, 1'b0);

        // backpressure
        pulse_start();
        run_frame(0, 1'b1, 1'b0);

        // reset at pass 5, c=3
        pulse_start();
        accept_n(0, 5 * (BS + 1) + 3);
        chk("pre_rst_valid", 32'(bf_req_valid), 32'd1);
        chk("pre_rst_win", 32'(obs_win()), 32'(model(5 * (BS + 1) + 3)));
        rst = 1'b1;
        #1;
        chk("mid_rst_win", 32'(obs_win()), 32'd0);
        chk("mid_rst_valid", 32'(bf_req_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_done", 32'(frame_done), 32'd0);
        end
        pulse_start();
        run_frame(0, 1'b0, 1'b0);

        // start during ISSUE is ignored
        pulse_start();
        run_frame(0, 1'b0, 1'b1);
        step();
        chk("poke_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
